// File: rtl/mc_mainfsm.sv
// Multicycle ARM-style main control FSM with a retired-instruction counter.
// Optional memory wait states via MEM_WAIT_EN (adds the MemReady port).
module mc_mainfsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
`ifdef MEM_WAIT_EN
  input  logic        MemReady,
`endif
  output logic        IRWrite,
  output logic        NextPC,
  output logic        Branch,
  output logic        RegW,
  output logic        MemW,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        ALUOp,
  output logic        IllegalOp,
  output logic        InstrDone,
  output logic [3:0]  State,
  output logic [31:0] RetireCount
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    UNKNOWN = 4'd10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic mem_rdy;
  logic ir_write, next_pc, branch, reg_w, mem_w;
  logic illegal_op, instr_done;
  logic unused_funct;

`ifdef MEM_WAIT_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = mem_rdy;
        next_pc   = mem_rdy;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_w      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        instr_done = mem_rdy;
        if (mem_rdy) state_d = FETCH;
      end
      EXECR: begin
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      UNKNOWN: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables and pulses are squashed while reset is held low.
  assign IRWrite   = reset & ir_write;
  assign NextPC    = reset & next_pc;
  assign Branch    = reset & branch;
  assign RegW      = reset & reg_w;
  assign MemW      = reset & mem_w;
  assign IllegalOp = reset & illegal_op;
  assign InstrDone = reset & instr_done;

  assign retire_cnt_d = InstrDone ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign State       = state_q;
  assign RetireCount = retire_cnt_q;

endmodule

// File: doc/mc_mainfsm.md
MC_MAINFSM -- requirements
Module: mc_mainfsm

Interface
REQ-001 The block SHALL have no parameters; the only build option is the macro in Configuration.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-005 Funct  input  6  Instr[25:20]; bit 5 = immediate, bit 0 = load/not-store.
REQ-006 MemReady  input  1  memory handshake, present only when MEM_WAIT_EN is defined.
REQ-007 IRWrite, NextPC, Branch, RegW, MemW  output  1 each  write enables and PC-update requests.
REQ-008 AdrSrc  output  1  address select: 0 PC, 1 Result.
REQ-009 ALUSrcA  output  2  ALU A select: 00 register A, 01 PC.
REQ-010 ALUSrcB  output  2  ALU B select: 00 WriteData, 01 ExtImm, 10 constant 4.
REQ-011 ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-012 ALUOp  output  1  1 = ALU decoder uses Funct, 0 = force ADD.
REQ-013 IllegalOp, InstrDone  output  1 each  single-cycle status pulses.
REQ-014 State  output  4  current state encoding, for debug.
REQ-015 RetireCount  output  32  count of completed instructions.

Function
REQ-016 The block SHALL be a Moore FSM with these states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, UNKNOWN 10.
REQ-017 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1, and then go to DECODE.
REQ-018 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10, then branch on Op/Funct.
REQ-019 DECODE next-state SHALL be: Op=00 with Funct[5]=0 to EXECR; Op=00 with Funct[5]=1 to EXECI; Op=01 to MEMADR; Op=10 to BRANCH; Op=11 to UNKNOWN.
REQ-020 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=0, then go to MEMRD if Funct[0]=1, else to MEMWR.
REQ-021 MEMRD SHALL drive AdrSrc=1, ResultSrc=00, then go to MEMWB.
REQ-022 MEMWB SHALL drive ResultSrc=01, RegW=1, then go to FETCH.
REQ-023 MEMWR SHALL drive AdrSrc=1, ResultSrc=00, MemW=1, then go to FETCH.
REQ-024 EXECR SHALL drive ALUSrcA=00, ALUSrcB=00, ALUOp=1; EXECI SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=1; both SHALL then go to ALUWB.
REQ-025 ALUWB SHALL drive ResultSrc=00, RegW=1, then go to FETCH.
REQ-026 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1, then go to FETCH.
REQ-027 UNKNOWN SHALL drive all enables 0, pulse IllegalOp=1 for one cycle, then go to FETCH.
REQ-028 Any output not listed for a state SHALL be 0.
REQ-029 InstrDone SHALL be 1 in the last cycle of MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN.
REQ-030 RetireCount SHALL increment by 1 on each clock edge where InstrDone=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 Without wait states, cycles per instruction SHALL be: LDR 5, STR 4, data-processing 4, branch 3, illegal 3.
REQ-032 Unused state encodings 11 to 15 SHALL go to FETCH on the next edge, with all outputs 0.

Reset
REQ-033 When reset=0 at a rising edge, State SHALL become FETCH and RetireCount SHALL become 0.
REQ-034 While reset=0, IRWrite, NextPC, Branch, RegW, MemW, IllegalOp and InstrDone SHALL be forced to 0 combinationally.
REQ-035 Asserting reset in any state, mid-instruction, SHALL abandon the instruction with no further write enables asserted.

Configuration
REQ-036 With MEM_WAIT_EN defined, the MemReady port SHALL exist, and FETCH, MEMRD and MEMWR SHALL hold their state until MemReady=1.
REQ-037 With MEM_WAIT_EN defined, IRWrite and NextPC in FETCH SHALL be asserted only in the cycle where MemReady=1.
REQ-038 With MEM_WAIT_EN defined, MemW SHALL stay asserted throughout MEMWR, and InstrDone in MEMWR SHALL fire only in the cycle where MemReady=1.
REQ-039 Without MEM_WAIT_EN, the MemReady port SHALL be absent and every state SHALL last exactly one cycle.

Verification
REQ-040 Reset held low for 3 cycles, then released -> State=0, RetireCount=0, no enable pulses; IRWrite=1 in the first cycle after release.
REQ-041 Op=01, Funct=011001 (LDR) -> states 0,1,2,3,4; RegW=1 and ResultSrc=01 in cycle 5; RetireCount +1.
REQ-042 Op=01, Funct=011000 (STR) -> states 0,1,2,5; MemW=1 in cycle 4 only.
REQ-043 Op=00, Funct[5]=1 (immediate) -> states 0,1,7,8; Op=10 -> states 0,1,9 with Branch=1; Op=11 -> IllegalOp pulse in cycle 3.
REQ-044 With MEM_WAIT_EN defined: MemReady low for 2 cycles in FETCH -> State holds 0 and IRWrite=0; IRWrite=1 in the third cycle.
REQ-045 Preload RetireCount to 0xFFFFFFFF and retire one instruction -> RetireCount=0; reset asserted mid-MEMRD -> State=0 on the next edge.
